// File: rtl/cordic_iter_hs.sv
// Iterative CORDIC engine with valid/ready handshakes on both sides.
// One micro-rotation per clock; supports rotation and vectoring modes.
// Results carry the uncompensated CORDIC gain.
module cordic_iter_hs #(
   parameter int WIDTH      = 16,
   parameter int FRAC_BITS  = WIDTH - 2,
   parameter int NUM_STAGES = 13,
   parameter int TAG_W      = 4
) (
   input  logic             clk_1,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t           state_reg, state_next;
   logic [4:0]       cnt_reg;
   logic [WIDTH-1:0] x_reg, y_reg, z_reg;
   logic             mode_reg;
   logic [TAG_W-1:0] tag_reg;
   logic             accept;
   logic             last_iter;

   // atan(2^-i) in radians; small angles use a short Taylor series
   function automatic real atan_pow2(input int i);
      real t;
      case (i)
         0:  return 0.7853981633974483;
         1:  return 0.4636476090008061;
         2:  return 0.24497866312686414;
         3:  return 0.12435499454676144;
         4:  return 0.06241880999595735;
         5:  return 0.031239833430268277;
         6:  return 0.015623728620476831;
         7:  return 0.007812341060101111;
         8:  return 0.0039062301319669718;
         9:  return 0.0019531225164788188;
         10: return 0.0009765621895593195;
         11: return 0.0004882812111948983;
         12: return 0.00024414062014936177;
         default: begin
            t = 2.0 ** (-i);
            return t - (t * t * t) / 3.0 + (t * t * t * t * t) / 5.0;
         end
      endcase
   endfunction

   // Angle constant scaled to the fixed-point format, rounded to nearest
   function automatic logic [WIDTH-1:0] atan_fixed(input int i);
      real v;
      v = atan_pow2(i) * (2.0 ** FRAC_BITS);
      return WIDTH'(longint'(v));
   endfunction

   logic [WIDTH-1:0] atan_tab [32];

   for (genvar gi = 0; gi < 32; gi++) begin : g_atan
      assign atan_tab[gi] = atan_fixed(gi);
   end

   // State register
   always_ff @(posedge clk_1) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   assign last_iter = (cnt_reg == 5'(NUM_STAGES - 1));

   // Next-state and handshake decode
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ITER;
         end
         ITER: begin
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_next = in_valid ? ITER : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);

   // One micro-rotation; direction chosen by the sign of z (rotation) or y (vectoring)
   logic             dir_pos;
   logic [WIDTH-1:0] x_shift, y_shift;
   logic [WIDTH-1:0] x_next, y_next, z_next;

   assign dir_pos = mode_reg ? y_reg[WIDTH-1] : ~z_reg[WIDTH-1];
   assign x_shift = $signed(x_reg) >>> cnt_reg;
   assign y_shift = $signed(y_reg) >>> cnt_reg;
   assign x_next  = dir_pos ? x_reg - y_shift : x_reg + y_shift;
   assign y_next  = dir_pos ? y_reg + x_shift : y_reg - x_shift;
   assign z_next  = dir_pos ? z_reg - atan_tab[cnt_reg] : z_reg + atan_tab[cnt_reg];

   // Operand capture on accept, then iterate in place; the working registers are the result
   always_ff @(posedge clk_1) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         x_reg    <= '0;
         y_reg    <= '0;
         z_reg    <= '0;
         mode_reg <= 1'b0;
         tag_reg  <= '0;
      end else if (accept) begin
         cnt_reg  <= '0;
         x_reg    <= x;
         y_reg    <= y;
         z_reg    <= z;
         mode_reg <= mode;
         tag_reg  <= in_tag;
      end else if (state_reg == ITER) begin
         cnt_reg  <= cnt_reg + 5'd1;
         x_reg    <= x_next;
         y_reg    <= y_next;
         z_reg    <= z_next;
      end
   end

   assign x_out   = x_reg;
   assign y_out   = y_reg;
   assign z_out   = z_reg;
   assign out_tag = tag_reg;

endmodule
